mux_n_scan: RTL and testbench
=============================

Name: mux_n_scan

Overview:
Parametrised N:1 data multiplexer with a registered output. It succeeds the fixed 2:1 combinational MUX2.
- Manual mode: the channel is chosen by an external select.
- Scan mode: an internal dwell counter steps through the channels round-robin.
- Sits between parallel sensor/data sources and a single downstream consumer (UART/display path).

Parameters:
CH, 4, number of input channels (2..16)
W, 8, data width per channel in bits
DWELL_W, 8, width of the dwell-count input

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
en  input  1  global enable; low freezes all state
mode  input  1  0 = manual, 1 = scan
sel  input  clog2(CH)  manual channel select
dwell  input  DWELL_W  scan mode: cycles per channel minus one
in_data  input  CH*W  packed inputs; channel k at bits [k*W +: W]
out_data  output  W  registered selected data
out_ch  output  clog2(CH)  channel index that produced out_data
out_valid  output  1  out_data/out_ch updated this cycle
wrap  output  1  one-cycle pulse when the scan index wraps CH-1 -> 0
sel_err  output  1  one-cycle pulse when manual sel >= CH

Behaviour:
- Reset (rst=1 at a clock edge): out_data=0, out_ch=0, out_valid=0, wrap=0, sel_err=0, scan index=0, dwell counter=0, state=IDLE.
  - Reset mid-scan or mid-dwell behaves identically; no partial state survives.
- States:
  - IDLE: after reset. On the first cycle with en=1, go to MANUAL if mode=0, or SCAN if mode=1.
  - MANUAL: while en=1, capture in_data[sel] into out_data, with out_ch=sel and out_valid=1.
    - Latency is exactly 1 cycle from sel/in_data to out_data.
    - If sel >= CH (only possible when CH is not a power of two): out_data and out_ch hold, out_valid=0, sel_err=1 for that cycle.
  - SCAN: while en=1, every cycle capture in_data[idx] into out_data, with out_ch=idx and out_valid=1.
    - The dwell counter counts 0..dwell. When it equals dwell, the counter clears and idx advances on the same edge.
    - dwell=0 advances idx every cycle.
    - At idx=CH-1, advancing sets idx=0 and pulses wrap on the cycle out_ch first shows 0.
    - A dwell value change takes effect on the next compare. If the counter is already > the new dwell, it advances on the next cycle.
- Mode changes (sampled each cycle):
  - SCAN->MANUAL: next edge selects sel; idx and dwell counter are cleared.
  - MANUAL->SCAN: starts at idx=0 with counter=0; first output is channel 0 and wrap does not pulse.
- en=0 in any state: out_data and out_ch hold, out_valid=0, wrap=0, sel_err=0, counter and idx frozen. Resuming continues from the frozen point.
- rst has priority over en and mode.

Optional Feature:
MUX_SCAN_MASK_EN
- Defined: adds input chan_mask[CH-1:0]; bit k=1 enables channel k for scanning.
  - On advance, scan skips to the next enabled channel (wrapping).
  - wrap pulses when the new index is <= the old one.
  - All bits 0: out_valid=0 and idx holds.
  - Manual mode ignores the mask.
- Undefined: no chan_mask port; all CH channels are scanned.

Decomposition:
- Shared package mux_scan_pkg:
  - Mode encodings MODE_MANUAL=1'b0, MODE_SCAN=1'b1.
  - State enum/localparams IDLE, MANUAL, SCAN.
- One sub-module, mux_scan_ctr: dwell counter plus index advance, wrap generation and mask skip.
  - Instantiated once; the top holds the state machine and output registers.

Test Plan:
- Reset then manual: rst 2 cycles; en=1, mode=0, CH=4, W=8, in_data={8'hD3,8'hC2,8'hB1,8'hA0}, sel=2 -> next cycle out_data=8'hC2, out_ch=2, out_valid=1; sel=0 -> out_data=8'hA0 one cycle later.
- Scan dwell=2: mode=1 -> out_ch sequence 0,0,0,1,1,1,2,2,2,3,3,3,0; wrap=1 only on the first 0 after 3.
- Scan dwell=0: out_ch=0,1,2,3,0,1; wrap every 4th cycle; out_data tracks the matching channel.
- Freeze/resume: in scan with dwell=3 at out_ch=1, counter=2, drop en 5 cycles -> outputs hold, out_valid=0; raise en -> one more cycle on ch1, then ch2.
- Mid-operation events:
  - Reset during scan at idx=3 -> all outputs 0 next cycle.
  - Scan->manual with sel=3 -> out_ch=3 next cycle; back to scan -> out_ch=0.
- Masked scan (MUX_SCAN_MASK_EN defined), chan_mask=4'b1010, dwell=0:
  - out_ch=1,3,1,3 with wrap on each return to 1.
  - mask=0 -> out_valid=0.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// ----------------------------------------------------------------------------
// mux_scan_pkg
// Shared definitions for the mux_n_scan multiplexer and its scan counter.
//   MODE_MANUAL / MODE_SCAN : encodings of the 'mode' input
//   state_e                 : controller states IDLE, MANUAL, SCAN
// No ports (package).
// ----------------------------------------------------------------------------
package mux_scan_pkg;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MANUAL = 2'd1,
      SCAN   = 2'd2
   } state_e;

endpackage

// File: rtl/mux_scan_ctr.sv
// ----------------------------------------------------------------------------
// mux_scan_ctr
// Dwell counter and round-robin channel index for scan mode. The counter
// runs 0..dwell_i on each channel; on the edge where it has reached dwell_i
// the counter clears and the index moves to the next enabled channel.
// A wrap flag is held for one step so the top can pulse 'wrap' in the cycle
// the wrapped index actually appears on the output.
// The optional channel mask (MUX_SCAN_MASK_EN in the top) arrives on mask_i;
// without it the top ties mask_i to all ones.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   clr_i         : clear index/counter/wrap flag (manual mode)
//   step_i        : advance one scan cycle (enabled scan)
//   dwell_i       : cycles per channel minus one
//   mask_i        : per-channel scan enable
//   idx_o         : channel to capture this cycle (always an enabled one)
//   any_o         : at least one channel enabled
//   wrap_pend_o   : idx_o is the first index after a wrap
// ----------------------------------------------------------------------------
module mux_scan_ctr
   import mux_scan_pkg::*;
#(
   parameter  int CH      = 4,
   parameter  int DWELL_W = 8,
   localparam int SEL_W   = $clog2(CH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr_i,
   input  logic               step_i,
   input  logic [DWELL_W-1:0] dwell_i,
   input  logic [CH-1:0]      mask_i,
   output logic [SEL_W-1:0]   idx_o,
   output logic               any_o,
   output logic               wrap_pend_o
);

   logic [DWELL_W-1:0] ctr_q, ctr_d;
   logic [SEL_W-1:0]   idx_q, idx_d;
   logic               pend_q, pend_d;
   logic [SEL_W-1:0]   cur_idx;
   logic [SEL_W-1:0]   nxt_idx;

   // First enabled channel strictly after 'from', wrapping at CH-1.
   // Returns 'from' when nothing is enabled.
   function automatic logic [SEL_W-1:0] next_en(input logic [SEL_W-1:0] from,
                                                input logic [CH-1:0]    m);
      logic [SEL_W-1:0] cand;
      logic [SEL_W-1:0] res;
      logic             found;
      cand  = from;
      res   = from;
      found = 1'b0;
      for (int k = 0; k < CH; k++) begin
         cand = (cand == SEL_W'(CH - 1)) ? '0 : cand + 1'b1;
         if (!found && m[cand]) begin
            res   = cand;
            found = 1'b1;
         end
      end
      return res;
   endfunction

   // If the mask changed under the current index, snap forward to the next
   // enabled channel so the captured channel is always an enabled one.
   assign cur_idx     = mask_i[idx_q] ? idx_q : next_en(idx_q, mask_i);
   assign nxt_idx     = next_en(cur_idx, mask_i);
   assign any_o       = |mask_i;
   assign idx_o       = cur_idx;
   assign wrap_pend_o = pend_q;

   always_comb begin
      ctr_d  = ctr_q;
      idx_d  = idx_q;
      pend_d = pend_q;
      if (clr_i) begin
         ctr_d  = '0;
         idx_d  = '0;
         pend_d = 1'b0;
      end else if (step_i) begin
         if (!any_o) begin
            pend_d = 1'b0;
         end else if (ctr_q >= dwell_i) begin
            // '>=' so a dwell shrunk below the running count advances now.
            ctr_d  = '0;
            idx_d  = nxt_idx;
            pend_d = (nxt_idx <= cur_idx);
         end else begin
            ctr_d  = ctr_q + 1'b1;
            idx_d  = cur_idx;
            pend_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctr_q  <= '0;
         idx_q  <= '0;
         pend_q <= 1'b0;
      end else begin
         ctr_q  <= ctr_d;
         idx_q  <= idx_d;
         pend_q <= pend_d;
      end
   end

endmodule

// File: rtl/mux_n_scan.sv
// ----------------------------------------------------------------------------
// mux_n_scan
// Parametrised CH:1 multiplexer with registered output. Manual mode selects
// the channel from 'sel'; scan mode steps round-robin with a programmable
// dwell time per channel (mux_scan_ctr).
// Optional build macro MUX_SCAN_MASK_EN adds input chan_mask[CH-1:0] that
// restricts which channels are scanned; manual mode ignores it.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (priority over all)
//   en         : global enable, low freezes all state
//   mode       : MODE_MANUAL / MODE_SCAN
//   sel        : manual channel select
//   dwell      : scan cycles per channel minus one
//   in_data    : packed inputs, channel k at [k*W +: W]
//   chan_mask  : scan channel enables (MUX_SCAN_MASK_EN only)
//   out_data   : registered selected data
//   out_ch     : channel that produced out_data
//   out_valid  : out_data/out_ch updated this cycle
//   wrap       : pulse on the first output after the scan index wraps
//   sel_err    : pulse when manual sel >= CH
// ----------------------------------------------------------------------------
module mux_n_scan
   import mux_scan_pkg::*;
#(
   parameter  int CH      = 4,
   parameter  int W       = 8,
   parameter  int DWELL_W = 8,
   localparam int SEL_W   = $clog2(CH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               mode,
   input  logic [SEL_W-1:0]   sel,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [CH*W-1:0]    in_data,
`ifdef MUX_SCAN_MASK_EN
   input  logic [CH-1:0]      chan_mask,
`endif
   output logic [W-1:0]       out_data,
   output logic [SEL_W-1:0]   out_ch,
   output logic               out_valid,
   output logic               wrap,
   output logic               sel_err
);

   localparam int NSEL = 1 << SEL_W;

   state_e           state_q, state_d;
   logic [W-1:0]     out_data_q, out_data_d;
   logic [SEL_W-1:0] out_ch_q, out_ch_d;
   logic             valid_q, valid_d;
   logic             wrap_q, wrap_d;
   logic             sel_err_q, sel_err_d;

   logic [W-1:0]     ch_data [NSEL];
   logic             sel_bad;
   logic [CH-1:0]    mask_eff;
   logic [SEL_W-1:0] scan_idx;
   logic             scan_any;
   logic             scan_wrap;

   // Unpack channels; pad up to a power of two so any sel value indexes a
   // defined entry (padding is never captured, sel_bad blocks it).
   generate
      for (genvar gi = 0; gi < NSEL; gi++) begin : g_ch
         if (gi < CH) begin : g_real
            assign ch_data[gi] = in_data[gi*W +: W];
         end else begin : g_pad
            assign ch_data[gi] = '0;
         end
      end
   endgenerate

   generate
      if (NSEL == CH) begin : g_sel_full
         assign sel_bad = 1'b0;
      end else begin : g_sel_part
         assign sel_bad = (sel > SEL_W'(CH - 1));
      end
   endgenerate

`ifdef MUX_SCAN_MASK_EN
   assign mask_eff = chan_mask;
`else
   assign mask_eff = '1;
`endif

   // Manual mode keeps the scan position at 0, so entering scan always
   // starts on channel 0 with a fresh dwell count and no wrap pending.
   mux_scan_ctr #(
      .CH      (CH),
      .DWELL_W (DWELL_W)
   ) u_ctr (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (en && (mode == MODE_MANUAL)),
      .step_i      (en && (mode == MODE_SCAN)),
      .dwell_i     (dwell),
      .mask_i      (mask_eff),
      .idx_o       (scan_idx),
      .any_o       (scan_any),
      .wrap_pend_o (scan_wrap)
   );

   // The edge that leaves IDLE already captures, so manual latency is one
   // cycle from the first enabled cycle.
   always_comb begin
      state_d    = state_q;
      out_data_d = out_data_q;
      out_ch_d   = out_ch_q;
      valid_d    = 1'b0;
      wrap_d     = 1'b0;
      sel_err_d  = 1'b0;

      if (en) begin
         state_d = (mode == MODE_SCAN) ? SCAN : MANUAL;
      end

      if (en) begin
         case (state_d)
            MANUAL: begin
               if (sel_bad) begin
                  sel_err_d = 1'b1;
               end else begin
                  out_data_d = ch_data[sel];
                  out_ch_d   = sel;
                  valid_d    = 1'b1;
               end
            end
            SCAN: begin
               if (scan_any) begin
                  out_data_d = ch_data[scan_idx];
                  out_ch_d   = scan_idx;
                  valid_d    = 1'b1;
                  wrap_d     = scan_wrap;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         out_data_q <= '0;
         out_ch_q   <= '0;
         valid_q    <= 1'b0;
         wrap_q     <= 1'b0;
         sel_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         out_data_q <= out_data_d;
         out_ch_q   <= out_ch_d;
         valid_q    <= valid_d;
         wrap_q     <= wrap_d;
         sel_err_q  <= sel_err_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;
   assign out_valid = valid_q;
   assign wrap      = wrap_q;
   assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_n_scan.sv
// ----------------------------------------------------------------------------
// tb_mux_n_scan
// Directed bench for mux_n_scan (CH=4, W=8, DWELL_W=8). Masked-scan steps
// are included when MUX_SCAN_MASK_EN is defined.
// ----------------------------------------------------------------------------
module tb_mux_n_scan;

   localparam int CH      = 4;
   localparam int W       = 8;
   localparam int DWELL_W = 8;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 en;
   logic                 mode;
   logic [1:0]           sel;
   logic [DWELL_W-1:0]   dwell;
   logic [CH*W-1:0]      in_data;
`ifdef MUX_SCAN_MASK_EN
   logic [CH-1:0]        chan_mask;
`endif
   logic [W-1:0]         out_data;
   logic [1:0]           out_ch;
   logic                 out_valid;
   logic                 wrap;
   logic                 sel_err;

   int                   checks = 0;
   int                   errors = 0;
   logic [7:0]           bytes_v [4];

   always #5 clk = ~clk;

   mux_n_scan #(
      .CH      (CH),
      .W       (W),
      .DWELL_W (DWELL_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .mode      (mode),
      .sel       (sel),
      .dwell     (dwell),
      .in_data   (in_data),
`ifdef MUX_SCAN_MASK_EN
      .chan_mask (chan_mask),
`endif
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .wrap      (wrap),
      .sel_err   (sel_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] b3, input logic [7:0] b2,
                       input logic [7:0] b1, input logic [7:0] b0);
      bytes_v[0] = b0;
      bytes_v[1] = b1;
      bytes_v[2] = b2;
      bytes_v[3] = b3;
      in_data    = {b3, b2, b1, b0};
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic [7:0] d, input logic [1:0] ch,
                             input logic v, input logic w, input logic e);
      $display("%-10s t=%0t out_ch=%0d out_data=%h valid=%b wrap=%b sel_err=%b",
               tag, $time, out_ch, out_data, out_valid, wrap, sel_err);
      chk({tag, ".data"},    32'(out_data),  32'(d));
      chk({tag, ".ch"},      32'(out_ch),    32'(ch));
      chk({tag, ".valid"},   32'(out_valid), 32'(v));
      chk({tag, ".wrap"},    32'(wrap),      32'(w));
      chk({tag, ".sel_err"}, 32'(sel_err),   32'(e));
   endtask

   int seq_d2 [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
   int seq_d0 [6]  = '{0, 1, 2, 3, 0, 1};
   int seq_d3 [7]  = '{0, 0, 0, 0, 1, 1, 1};

   initial begin
      // Reset, with en/mode active to show reset priority.
      rst   = 1'b1;
      en    = 1'b0;
      mode  = 1'b0;
      sel   = 2'd0;
      dwell = 8'd0;
      load(8'hD3, 8'hC2, 8'hB1, 8'hA0);
`ifdef MUX_SCAN_MASK_EN
      chan_mask = 4'b1111;
`endif
      tick();
      en   = 1'b1;
      mode = 1'b1;
      tick();
      expect_out("reset", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);

      // Manual selection, one-cycle latency.
      rst  = 1'b0;
      mode = 1'b0;
      sel  = 2'd2;
      tick();
      expect_out("man_s2", 8'hC2, 2'd2, 1'b1, 1'b0, 1'b0);
      sel = 2'd0;
      tick();
      expect_out("man_s0", 8'hA0, 2'd0, 1'b1, 1'b0, 1'b0);
      sel = 2'd3;
      tick();
      expect_out("man_s3", 8'hD3, 2'd3, 1'b1, 1'b0, 1'b0);

      // Scan with dwell=2: three cycles per channel, wrap on return to 0.
      mode  = 1'b1;
      dwell = 8'd2;
      for (int i = 0; i < 13; i++) begin
         tick();
         expect_out("scan_d2", bytes_v[seq_d2[i]], 2'(seq_d2[i]), 1'b1, 1'(i == 12), 1'b0);
      end

      // Manual hop clears scan position; then scan dwell=0 on new data.
      load(8'h0F, 8'hF0, 8'h55, 8'hAA);
      mode = 1'b0;
      sel  = 2'd1;
      tick();
      expect_out("man_s1", 8'h55, 2'd1, 1'b1, 1'b0, 1'b0);
      mode  = 1'b1;
      dwell = 8'd0;
      for (int i = 0; i < 6; i++) begin
         tick();
         expect_out("scan_d0", bytes_v[seq_d0[i]], 2'(seq_d0[i]), 1'b1, 1'(i == 4), 1'b0);
      end

      // Freeze/resume with dwell=3 after three cycles on ch1.
      mode = 1'b0;
      sel  = 2'd2;
      tick();
      expect_out("man_s2b", 8'hF0, 2'd2, 1'b1, 1'b0, 1'b0);
      mode  = 1'b1;
      dwell = 8'd3;
      for (int i = 0; i < 7; i++) begin
         tick();
         expect_out("scan_d3", bytes_v[seq_d3[i]], 2'(seq_d3[i]), 1'b1, 1'b0, 1'b0);
      end
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         expect_out("frozen", 8'h55, 2'd1, 1'b0, 1'b0, 1'b0);
      end
      en = 1'b1;
      tick();
      expect_out("resume1", 8'h55, 2'd1, 1'b1, 1'b0, 1'b0);
      tick();
      expect_out("resume2", 8'hF0, 2'd2, 1'b1, 1'b0, 1'b0);

      // Reach idx=3 then reset mid-scan; no wrap may survive.
      dwell = 8'd0;
      tick();
      expect_out("pre_rst2", 8'hF0, 2'd2, 1'b1, 1'b0, 1'b0);
      tick();
      expect_out("pre_rst3", 8'h0F, 2'd3, 1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      expect_out("mid_rst", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      tick();
      expect_out("post_rst", 8'hAA, 2'd0, 1'b1, 1'b0, 1'b0);

      // Scan -> manual -> scan.
      mode = 1'b0;
      sel  = 2'd3;
      tick();
      expect_out("to_man", 8'h0F, 2'd3, 1'b1, 1'b0, 1'b0);
      mode = 1'b1;
      tick();
      expect_out("to_scan", 8'hAA, 2'd0, 1'b1, 1'b0, 1'b0);

      // Dwell shrunk below the running count advances on the next cycle.
      dwell = 8'd5;
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_out("dwell5", 8'h55, 2'd1, 1'b1, 1'b0, 1'b0);
      end
      dwell = 8'd1;
      tick();
      expect_out("shrink1", 8'h55, 2'd1, 1'b1, 1'b0, 1'b0);
      tick();
      expect_out("shrink2", 8'hF0, 2'd2, 1'b1, 1'b0, 1'b0);

`ifdef MUX_SCAN_MASK_EN
      // Masked scan over channels 1 and 3, then an empty mask.
      mode = 1'b0;
      sel  = 2'd0;
      tick();
      expect_out("man_m", 8'hAA, 2'd0, 1'b1, 1'b0, 1'b0);
      mode      = 1'b1;
      dwell     = 8'd0;
      chan_mask = 4'b1010;
      tick();
      expect_out("mask_1a", 8'h55, 2'd1, 1'b1, 1'b0, 1'b0);
      tick();
      expect_out("mask_3a", 8'h0F, 2'd3, 1'b1, 1'b0, 1'b0);
      tick();
      expect_out("mask_1b", 8'h55, 2'd1, 1'b1, 1'b1, 1'b0);
      tick();
      expect_out("mask_3b", 8'h0F, 2'd3, 1'b1, 1'b0, 1'b0);
      chan_mask = 4'b0000;
      tick();
      expect_out("mask_0", 8'h0F, 2'd3, 1'b0, 1'b0, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
